guess_index_decoder: RTL and testbench
======================================

Name: guess_index_decoder

Overview:
- Inverse of the guess generator: takes a packed 128-bit guess string, its charset code and length, and returns the linear keyspace index that generator would need to produce that guess.
- Sits on the result path after the hash-compare stage, so a cracked hit or checkpoint guess is reported to the host as a compact index, not raw bytes.
- Serial mixed-radix (Horner) conversion, one character per cycle, with valid/ready handshakes on both sides.

Parameters:
GUESS_BYTES, 16, maximum guess length in characters; guess bus is 8*GUESS_BYTES bits
INDEX_WIDTH, 96, width of decoded index; must hold 62^GUESS_BYTES - 1

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  guess/charset/guesslen valid
in_ready  output  1  decoder can accept a guess
guess  input  128  char i in bits [8i+7:8i]; char 0 is the least-significant (fastest-changing) digit
charset  input  3  0=a-z(26), 1=A-Z(26), 2=0-9(10), 3=a-z0-9(36), 4=a-zA-Z0-9(62), 5-7 reserved
guesslen  input  5  number of characters, legal 1..GUESS_BYTES
out_valid  output  1  index/error valid
out_ready  input  1  downstream accepts result
index  output  INDEX_WIDTH  decoded linear index
error  output  1  decode failed (bad length, reserved charset, or out-of-charset char)

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; index=0; error=0; internal accumulator and counters=0.
- Digit map per charset, in the generator's ordering: lowercase 'a'..'z'->0..25; uppercase 'A'..'Z'->0..25; digits '0'..'9'->0..9; charset 3: 'a'..'z'->0..25, '0'..'9'->26..35; charset 4: 'a'..'z'->0..25, 'A'..'Z'->26..51, '0'..'9'->52..61.
- IDLE: in_ready=1. When in_valid=1, latch guess, charset and guesslen, set acc=0, pos=guesslen-1, and move to DECODE.
- Bad input: if guesslen=0, guesslen>GUESS_BYTES, or charset>=5, skip DECODE, go straight to DONE with error=1 and index=0 (one cycle after accept).
- DECODE: each cycle, acc <= acc*radix + digit(char[pos]) and pos decrements. After char 0 is processed, go to DONE.
  - Any char not in the charset sets a sticky error. On entry to DONE, index=0 and error=1.
  - Arithmetic is INDEX_WIDTH unsigned. The multiply is by a constant-select radix (shift/add allowed). No overflow is possible within the legal ranges.
- Latency: accept edge to out_valid rising = guesslen cycles for legal input; 1 cycle for bad input.
- DONE: out_valid=1; index and error held stable. in_ready=0 in DECODE and DONE, so no new accept occurs. On out_valid&&out_ready, return to IDLE with out_valid=0 next cycle.
- Back-to-back operation: in_ready rises in the cycle after the output handshake. There is no overlap between consecutive decodes.
- in_valid is ignored outside IDLE. Latched inputs are unaffected by bus changes after accept.
- Reset asserted mid-DECODE or mid-DONE: immediate return to reset values; the in-flight result is discarded and never presented.

Optional Feature:
- Macro: GUESS_DECODE_COUNT_EN.
- Defined: adds output port decoded_count [31:0], reset to 0. It increments on each output handshake with error=0, saturates at 32'hFFFFFFFF, and does not count errored results.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Lowercase: charset=0, guesslen=2, guess bytes {char1='a', char0='b'} -> index=1, error=0, out_valid exactly 2 cycles after accept. Guess "zz" -> index=675.
- Digits: charset=2, guesslen=3, char0='9', char1='0', char2='1' -> index=109. Max length: charset=4, guesslen=16, all '9' -> index=62^16-1, out_valid after 16 cycles.
- Errors:
  - charset=0 with char0='A' -> error=1, index=0.
  - guesslen=0 -> error=1 after 1 cycle.
  - charset=6 -> error=1.
  - guesslen=17 -> error=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> index/error stable, in_ready=0, extra in_valid pulses ignored. Release -> in_ready=1 on the next cycle; the next guess decodes correctly.
- Reset mid-operation: assert reset_n=0 on the 3rd DECODE cycle of a guesslen=8 decode -> out_valid=0, in_ready=1, index=0 immediately. A fresh guess then decodes correctly. With GUESS_DECODE_COUNT_EN defined, decoded_count=0 after reset.

Source files
------------

// File: rtl/guess_index_decoder_if.sv
// Handshake bundle for guess_index_decoder: a guess request on one side and a
// decoded-index response on the other.
interface guess_index_decoder_if #(
  parameter int unsigned GUESS_BYTES = 16,
  parameter int unsigned INDEX_WIDTH = 96
);
  logic                     in_valid;
  logic                     in_ready;
  logic [8*GUESS_BYTES-1:0] guess;
  logic [2:0]               charset;
  logic [4:0]               guesslen;
  logic                     out_valid;
  logic                     out_ready;
  logic [INDEX_WIDTH-1:0]   index;
  logic                     error;

  modport master (
    output in_valid, guess, charset, guesslen, out_ready,
    input  in_ready, out_valid, index, error
  );

  modport slave (
    input  in_valid, guess, charset, guesslen, out_ready,
    output in_ready, out_valid, index, error
  );
endinterface

// File: rtl/guess_index_decoder.sv
// Serial mixed-radix (Horner) decoder: guess string -> linear keyspace index.
// Optional GUESS_DECODE_COUNT_EN adds a saturating count of error-free results.
module guess_index_decoder #(
  parameter int unsigned GUESS_BYTES = 16,
  parameter int unsigned INDEX_WIDTH = 96
) (
  input  logic clk,
  input  logic reset_n,
  guess_index_decoder_if.slave bus
`ifdef GUESS_DECODE_COUNT_EN
  ,
  output logic [31:0] decoded_count
`endif
);

  typedef enum logic [1:0] {StIdle, StDecode, StDone} state_e;

  state_e                   state_q, state_d;
  logic [8*GUESS_BYTES-1:0] guess_q, guess_d;
  logic [2:0]               charset_q, charset_d;
  logic [4:0]               pos_q, pos_d;
  logic [INDEX_WIDTH-1:0]   acc_q, acc_d;
  logic                     err_q, err_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic                     error_q, error_d;

  logic [INDEX_WIDTH-1:0]   mul;
  logic [7:0]               cur_char;
  logic [6:0]               dmap;
  logic                     bad_in;

  // Returns {in_charset, digit} using the generator's symbol ordering.
  function automatic logic [6:0] map_char(input logic [2:0] cs, input logic [7:0] c);
    logic       lo, up, dg;
    logic [7:0] d;
    logic       ok;
    lo = (c >= 8'h61) && (c <= 8'h7a);
    up = (c >= 8'h41) && (c <= 8'h5a);
    dg = (c >= 8'h30) && (c <= 8'h39);
    d  = 8'd0;
    ok = 1'b0;
    case (cs)
      3'd0: begin ok = lo; d = c - 8'h61; end
      3'd1: begin ok = up; d = c - 8'h41; end
      3'd2: begin ok = dg; d = c - 8'h30; end
      3'd3: begin
        ok = lo | dg;
        d  = lo ? (c - 8'h61) : (c - 8'h30 + 8'd26);
      end
      3'd4: begin
        ok = lo | up | dg;
        d  = lo ? (c - 8'h61) : up ? (c - 8'h41 + 8'd26) : (c - 8'h30 + 8'd52);
      end
      default: begin ok = 1'b0; d = 8'd0; end
    endcase
    return {ok, d[5:0]};
  endfunction

  assign cur_char = guess_q[8*pos_q +: 8];
  assign dmap     = map_char(charset_q, cur_char);
  assign bad_in   = (bus.guesslen == 5'd0) || (32'(bus.guesslen) > GUESS_BYTES) ||
                    (bus.charset >= 3'd5);

  always_comb begin
    mul = '0;
    case (charset_q)
      3'd0, 3'd1: mul = acc_q * INDEX_WIDTH'(26);
      3'd2:       mul = acc_q * INDEX_WIDTH'(10);
      3'd3:       mul = acc_q * INDEX_WIDTH'(36);
      3'd4:       mul = acc_q * INDEX_WIDTH'(62);
      default:    mul = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    charset_d = charset_q;
    pos_d     = pos_q;
    acc_d     = acc_q;
    err_d     = err_q;
    index_d   = index_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          guess_d   = bus.guess;
          charset_d = bus.charset;
          acc_d     = '0;
          state_d   = StDecode;
          // Bad requests spend one throwaway DECODE cycle so they also answer in 1 cycle.
          if (bad_in) begin
            pos_d = 5'd0;
            err_d = 1'b1;
          end else begin
            pos_d = bus.guesslen - 5'd1;
            err_d = 1'b0;
          end
        end
      end
      StDecode: begin
        acc_d = mul + INDEX_WIDTH'(dmap[5:0]);
        if (!dmap[6]) err_d = 1'b1;
        pos_d = pos_q - 5'd1;
        if (pos_q == 5'd0) begin
          state_d = StDone;
          index_d = err_d ? '0 : acc_d;
          error_d = err_d;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      guess_q   <= '0;
      charset_q <= '0;
      pos_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      index_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      charset_q <= charset_d;
      pos_q     <= pos_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      index_q   <= index_d;
      error_q   <= error_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.index     = index_q;
  assign bus.error     = error_q;

`ifdef GUESS_DECODE_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if ((state_q == StDone) && bus.out_ready && !error_q && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign decoded_count = count_q;
`endif

endmodule

// File: tb/tb_guess_index_decoder.sv
// Self-checking bench for guess_index_decoder: directed cases plus random guesses
// checked against a place-value reference model.
module tb_guess_index_decoder;
  localparam int unsigned GB = 16;
  localparam int unsigned IW = 96;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  guess_index_decoder_if #(.GUESS_BYTES(GB), .INDEX_WIDTH(IW)) dif ();

`ifdef GUESS_DECODE_COUNT_EN
  logic [31:0] decoded_count;
  logic [31:0] exp_count = '0;
`endif

  guess_index_decoder #(.GUESS_BYTES(GB), .INDEX_WIDTH(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif)
`ifdef GUESS_DECODE_COUNT_EN
    ,
    .decoded_count (decoded_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string cs_str(input int cs);
    string lo, up, dg;
    lo = "abcdefghijklmnopqrstuvwxyz";
    up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    dg = "0123456789";
    case (cs)
      0: return lo;
      1: return up;
      2: return dg;
      3: return {lo, dg};
      default: return {lo, up, dg};
    endcase
  endfunction

  // index = sum over i of digit(char i) * radix^i; any bad field or char -> error.
  function automatic void model(input logic [127:0] g, input int cs, input int len,
                                output logic [IW-1:0] idx, output logic err,
                                output int lat);
    string        s;
    logic [127:0] val, place;
    int           d;
    if (len < 1 || len > GB || cs > 4) begin
      idx = '0; err = 1'b1; lat = 1;
      return;
    end
    s = cs_str(cs);
    val = '0; place = 128'd1; err = 1'b0;
    for (int i = 0; i < len; i++) begin
      d = -1;
      for (int k = 0; k < s.len(); k++) if (s[k] == g[8*i +: 8]) d = k;
      if (d < 0) err = 1'b1;
      else val = val + 128'(d) * place;
      place = place * 128'(s.len());
    end
    idx = err ? '0 : val[IW-1:0];
    lat = len;
  endfunction

  // String is written most-significant character first, as it reads.
  function automatic logic [127:0] mk(input string s);
    logic [127:0] g;
    g = '0;
    for (int i = 0; i < s.len(); i++) g[8*i +: 8] = s[s.len()-1-i];
    return g;
  endfunction

  task automatic run(input logic [127:0] g, input int cs, input int len, input int hold,
                     input string tag);
    logic [IW-1:0] e_idx;
    logic          e_err;
    int            e_lat;
    int            cyc;
    model(g, cs, len, e_idx, e_err, e_lat);
    @(negedge clk);
    check({tag, ".in_ready"}, 128'(dif.in_ready), 128'd1);
    dif.in_valid = 1'b1;
    dif.guess    = g;
    dif.charset  = 3'(cs);
    dif.guesslen = 5'(len);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.guess    = {$urandom(), $urandom(), $urandom(), $urandom()};
    dif.charset  = 3'($urandom_range(0, 7));
    dif.guesslen = 5'($urandom_range(0, 31));
    cyc = 0;
    while (!dif.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 128'(cyc), 128'(e_lat));
    check({tag, ".index"}, 128'(dif.index), 128'(e_idx));
    check({tag, ".error"}, 128'(dif.error), 128'(e_err));
    for (int h = 0; h < hold; h++) begin
      dif.in_valid = 1'b1;
      dif.guess    = {$urandom(), $urandom(), $urandom(), $urandom()};
      dif.guesslen = 5'd1;
      dif.charset  = 3'd0;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 128'(dif.out_valid), 128'd1);
      check({tag, ".hold_ready"}, 128'(dif.in_ready), 128'd0);
      check({tag, ".hold_index"}, 128'(dif.index), 128'(e_idx));
      check({tag, ".hold_error"}, 128'(dif.error), 128'(e_err));
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    check({tag, ".out_valid_clr"}, 128'(dif.out_valid), 128'd0);
    check({tag, ".in_ready_back"}, 128'(dif.in_ready), 128'd1);
`ifdef GUESS_DECODE_COUNT_EN
    if (!e_err && exp_count != '1) exp_count = exp_count + 32'd1;
    check({tag, ".count"}, 128'(decoded_count), 128'(exp_count));
`endif
  endtask

  initial begin
    logic [127:0] g;
    string        s;
    int           cs, len;

    dif.in_valid  = 1'b0;
    dif.guess     = '0;
    dif.charset   = '0;
    dif.guesslen  = '0;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 128'(dif.in_ready), 128'd1);
    check("rst.out_valid", 128'(dif.out_valid), 128'd0);
    check("rst.index", 128'(dif.index), 128'd0);
    check("rst.error", 128'(dif.error), 128'd0);
`ifdef GUESS_DECODE_COUNT_EN
    check("rst.count", 128'(decoded_count), 128'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    run(mk("ab"), 0, 2, 0, "lower_ab");
    run(mk("zz"), 0, 2, 0, "lower_zz");
    run(mk("QZ"), 1, 2, 0, "upper");
    run(mk("109"), 2, 3, 0, "digits");
    run(mk("z9a0"), 3, 4, 0, "alnum36");
    run(mk("9999999999999999"), 4, 16, 0, "max_len");
    run(mk("A"), 0, 1, 0, "bad_char");
    run(mk("ab"), 0, 0, 0, "len0");
    run(mk("ab"), 6, 2, 0, "cs6");
    run(mk("ab"), 0, 17, 0, "len17");
    run(mk("hello"), 4, 5, 10, "backpressure");
    run(mk("next"), 0, 4, 0, "after_bp");

    // Reset during the third DECODE cycle of a length-8 decode.
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.guess    = mk("abcdefgh");
    dif.charset  = 3'd0;
    dif.guesslen = 5'd8;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("midrst.out_valid", 128'(dif.out_valid), 128'd0);
    check("midrst.in_ready", 128'(dif.in_ready), 128'd1);
    check("midrst.index", 128'(dif.index), 128'd0);
`ifdef GUESS_DECODE_COUNT_EN
    exp_count = '0;
    check("midrst.count", 128'(decoded_count), 128'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    run(mk("Zebra9"), 4, 6, 0, "after_rst");

    for (int t = 0; t < 30; t++) begin
      cs  = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 4));
      len = $urandom_range(1, 16);
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 17;
      s = cs_str(cs);
      g = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 24) != 0) g[8*i +: 8] = s[$urandom_range(0, s.len() - 1)];
      run(g, cs, len, int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
